// File: rtl/generatore_mosse.sv
// ----------------------------------------------------------------------------
// generatore_mosse
// Player-side move generator for the two-player referee. Starts a game with
// the configured manche count, then plays pseudo-random legal move pairs,
// reads back manche/game results and keeps win/draw statistics.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   AVVIA               start request (sampled in RIPOSO only)
//   NUM_MANCHE[3:0]     game length code handed to the referee in SETUP
//   SEME[7:0]           LFSR seed loaded on start (0 keeps current value)
//   MANCHE[1:0]         referee manche result (00 invalid, 01/10 win, 11 draw)
//   PARTITA[1:0]        referee game result (00 running, else as MANCHE)
//   PRIMO, SECONDO      player moves (01/10/11, 00 = no move)
//   INIZIA              start strobe to the referee
//   OCCUPATO            game in progress
//   FINITO              one-cycle end-of-game pulse
//   ERRORE              game aborted after MAX_TENTATIVI rejected manches
//   VITTORIE_PRIMO/VITTORIE_SECONDO/PAREGGI  saturating game statistics
//
// Optional build macro: INIEZIONE_ERRORI_EN -- forces PRIMO=00 in GIOCA when
// LFSR[7:5]==000 so the referee reject path gets exercised.
// ----------------------------------------------------------------------------
module generatore_mosse #(
    parameter int MAX_TENTATIVI = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       AVVIA,
    input  logic [3:0] NUM_MANCHE,
    input  logic [7:0] SEME,
    input  logic [1:0] MANCHE,
    input  logic [1:0] PARTITA,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    output logic       INIZIA,
    output logic       OCCUPATO,
    output logic       FINITO,
    output logic       ERRORE,
    output logic [7:0] VITTORIE_PRIMO,
    output logic [7:0] VITTORIE_SECONDO,
    output logic [7:0] PAREGGI
);

    localparam logic [2:0] RIPOSO = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] GIOCA  = 3'd2;
    localparam logic [2:0] ATTESA = 3'd3;
    localparam logic [2:0] FINE   = 3'd4;

    localparam logic [3:0] TENT_MAX = 4'(MAX_TENTATIVI);

    logic [2:0] r_stato;
    logic       r_setup_cnt;
    logic [7:0] r_lfsr;
    logic [3:0] r_tent;
    logic [1:0] r_vinc;        // last manche winner: 00 none, 01 PRIMO, 10 SECONDO
    logic [1:0] r_mossa_vinc;  // move the last winner played
    logic [1:0] r_gioc_p;      // pair actually driven in the last GIOCA
    logic [1:0] r_gioc_s;
    logic       r_errore;
    logic [7:0] r_vp;
    logic [7:0] r_vs;
    logic [7:0] r_pa;

    logic       w_fb;
    logic [1:0] w_raw_p;
    logic [1:0] w_raw_s;
    logic [1:0] w_legal_p;
    logic [1:0] w_mossa_p;
    logic [1:0] w_mossa_s;
    logic [3:0] w_tent_inc;

    function automatic logic [1:0] f_mappa(input logic [1:0] raw);
        case (raw)
            2'd1:    f_mappa = 2'b10;
            2'd2:    f_mappa = 2'b11;
            default: f_mappa = 2'b01;   // raw 0 and 3 both map to 01
        endcase
    endfunction

    // (m mod 3) + 1 : 01->10, 10->11, 11->01
    function automatic logic [1:0] f_ruota(input logic [1:0] m);
        case (m)
            2'b01:   f_ruota = 2'b10;
            2'b10:   f_ruota = 2'b11;
            default: f_ruota = 2'b01;
        endcase
    endfunction

    // Fibonacci LFSR, taps 8,6,5,4
    assign w_fb      = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_raw_p   = f_mappa(r_lfsr[1:0]);
    assign w_raw_s   = f_mappa(r_lfsr[3:2]);

    // A manche winner may not repeat its winning move next manche.
    assign w_legal_p = (r_vinc == 2'b01 && w_raw_p == r_mossa_vinc) ? f_ruota(w_raw_p) : w_raw_p;
    assign w_mossa_s = (r_vinc == 2'b10 && w_raw_s == r_mossa_vinc) ? f_ruota(w_raw_s) : w_raw_s;

`ifdef INIEZIONE_ERRORI_EN
    assign w_mossa_p = (r_lfsr[7:5] == 3'b000) ? 2'b00 : w_legal_p;
`else
    assign w_mossa_p = w_legal_p;
`endif

    assign w_tent_inc = r_tent + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stato      <= RIPOSO;
            r_setup_cnt  <= 1'b0;
            r_lfsr       <= 8'hA5;
            r_tent       <= 4'd0;
            r_vinc       <= 2'b00;
            r_mossa_vinc <= 2'b00;
            r_gioc_p     <= 2'b00;
            r_gioc_s     <= 2'b00;
            r_errore     <= 1'b0;
            r_vp         <= 8'd0;
            r_vs         <= 8'd0;
            r_pa         <= 8'd0;
        end else begin
            case (r_stato)
                RIPOSO: begin
                    if (AVVIA) begin
                        r_stato      <= SETUP;
                        r_setup_cnt  <= 1'b0;
                        r_errore     <= 1'b0;
                        r_tent       <= 4'd0;
                        r_vinc       <= 2'b00;
                        r_mossa_vinc <= 2'b00;
                        if (SEME != 8'd0) r_lfsr <= SEME;
                    end
                end
                SETUP: begin
                    if (r_setup_cnt) r_stato <= GIOCA;
                    else             r_setup_cnt <= 1'b1;
                end
                GIOCA: begin
                    r_lfsr   <= {r_lfsr[6:0], w_fb};
                    r_gioc_p <= w_mossa_p;
                    r_gioc_s <= w_mossa_s;
                    r_stato  <= ATTESA;
                end
                ATTESA: begin
                    if (PARTITA != 2'b00) begin
                        // game result has priority over a rejected manche
                        case (PARTITA)
                            2'b01:   if (r_vp != 8'hFF) r_vp <= r_vp + 8'd1;
                            2'b10:   if (r_vs != 8'hFF) r_vs <= r_vs + 8'd1;
                            default: if (r_pa != 8'hFF) r_pa <= r_pa + 8'd1;
                        endcase
                        r_stato <= FINE;
                    end else if (MANCHE == 2'b00) begin
                        r_tent <= w_tent_inc;
                        if (w_tent_inc == TENT_MAX) begin
                            r_errore <= 1'b1;
                            r_stato  <= FINE;
                        end else begin
                            r_stato <= GIOCA;
                        end
                    end else begin
                        r_tent <= 4'd0;
                        case (MANCHE)
                            2'b01: begin
                                r_vinc       <= 2'b01;
                                r_mossa_vinc <= r_gioc_p;
                            end
                            2'b10: begin
                                r_vinc       <= 2'b10;
                                r_mossa_vinc <= r_gioc_s;
                            end
                            default: begin
                                r_vinc       <= 2'b00;
                                r_mossa_vinc <= 2'b00;
                            end
                        endcase
                        r_stato <= GIOCA;
                    end
                end
                FINE:    r_stato <= RIPOSO;
                default: r_stato <= RIPOSO;
            endcase
        end
    end

    // Moore outputs: decoded from state only, so an asynchronous reset
    // idles them immediately.
    always_comb begin
        PRIMO   = 2'b00;
        SECONDO = 2'b00;
        INIZIA  = 1'b0;
        case (r_stato)
            SETUP: begin
                INIZIA  = 1'b1;
                PRIMO   = NUM_MANCHE[3:2];
                SECONDO = NUM_MANCHE[1:0];
            end
            GIOCA: begin
                PRIMO   = w_mossa_p;
                SECONDO = w_mossa_s;
            end
            default: ;
        endcase
    end

    assign OCCUPATO         = (r_stato != RIPOSO);
    assign FINITO           = (r_stato == FINE);
    assign ERRORE           = r_errore;
    assign VITTORIE_PRIMO   = r_vp;
    assign VITTORIE_SECONDO = r_vs;
    assign PAREGGI          = r_pa;

endmodule
